sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like master port between two requesters: the fetch stage instruction port (inst_*) and the memory stage data port (data_*).
- Sits between the pipeline and the cache/bus bridge.
- Allows one outstanding transaction. Data has fixed priority, with a starvation guard that forces an instruction grant after a run of data grants.
- Replaces the ad-hoc inst/data muxing in front of the bridge.

Parameters:
- MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is pending before inst is forced (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- inst_req  in  1  fetch request
- inst_wr  in  1  always 0 from fetch; forwarded as-is
- inst_size  in  2  access size
- inst_addr  in  32  fetch address
- inst_wdata  in  32  unused data; forwarded as-is
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req  in  1  memory stage request (m_data_req)
- data_wr  in  1  write flag
- data_size  in  2  access size
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- bus_req  out  1  master request
- bus_wr  out  1  write flag
- bus_size  out  2  access size
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  slave accepted request
- bus_data_ok  in  1  slave response valid
- bus_rdata  in  32  slave read data
- busy  out  1  1 while in WAIT

Behaviour:
- FSM states: IDLE, WAIT. Registered state: state, owner (0=inst, 1=data), streak counter (4 bits).
- Reset (async, rst=1): state=IDLE, owner=0, streak=0. All outputs are 0 during reset and in the first cycle after it.
- IDLE winner selection (combinational, same cycle):
  - Only one of inst_req / data_req asserted: that requester wins.
  - Both asserted: data wins if streak < MAX_DATA_STREAK; otherwise inst wins.
- IDLE bus drive:
  - bus_req = winner's req; bus_wr/size/addr/wdata come combinationally from the winner.
  - With no request, bus_req=0 and the bus fields are 0.
- IDLE acceptance:
  - If bus_addr_ok=1 with bus_req=1: assert the winner's *_addr_ok the same cycle, latch owner=winner, go to WAIT.
  - No registered request in the path: request-to-bus latency is 0 cycles.
- Streak update, on each accepted transfer only:
  - Data accepted while inst_req=1: streak += 1, saturating at 15.
  - Inst accepted: streak = 0.
  - Data accepted while inst_req=0: streak = 0.
- WAIT:
  - bus_req=0; both *_addr_ok=0; busy=1.
  - When bus_data_ok=1: assert owner's *_data_ok for exactly that cycle and route bus_rdata to owner's *_rdata. The non-owner's rdata is 0. Return to IDLE.
  - A new request can be accepted no earlier than the cycle after data_ok (at most one outstanding).
- bus_addr_ok and bus_data_ok both 1 in IDLE: bus_data_ok is ignored (nothing outstanding). Acceptance proceeds normally.
- bus_data_ok in WAIT in the same cycle as a new upstream req: the req is not accepted that cycle; it is evaluated in IDLE next cycle.
- Requester deasserts req before addr_ok: no transfer. Winner selection re-evaluates each IDLE cycle. Grant is not sticky.
- Inputs are not checked for stability. Upstream holds req and fields until addr_ok (SRAM-like rule).
- Reset asserted in WAIT: transaction abandoned, state=IDLE. The bridge is reset by the same rst.
- Writes (data_wr=1) still wait for bus_data_ok before returning to IDLE.

Test Plan:
- Inst only: inst_req=1, addr=0xBFC00000, bus_addr_ok=1 in cycle 0 and bus_data_ok=1 in cycle 2 with rdata=0x3C080001 -> inst_addr_ok=1 in cycle 0, inst_data_ok=1 and inst_rdata=0x3C080001 in cycle 2, data_data_ok=0 throughout.
- Simultaneous requests, streak=0: inst_req=data_req=1, data_addr=0x80001000, wr=1, wdata=0xDEADBEEF -> bus_addr=0x80001000, bus_wr=1, bus_wdata=0xDEADBEEF, data_addr_ok=1, inst_addr_ok=0. After data_ok, the next cycle grants data again and streak=1.
- Starvation guard: both req held continuously, MAX_DATA_STREAK=4, bus completes each transfer in 2 cycles -> 4 data grants, 5th grant is inst, streak=0 after it, then data is granted again.
- Back-to-back: bus_data_ok and a new data_req in the same WAIT cycle -> no addr_ok that cycle; addr_ok in the following IDLE cycle; bus_req=0 throughout WAIT.
- Reset mid-WAIT: owner=data, WAIT, assert rst for 1 cycle with no clock edge -> busy=0 and all *_ok=0 immediately. A later stray bus_data_ok in IDLE produces no *_data_ok.
- Stray data_ok: in IDLE with no request, bus_data_ok=1, bus_rdata=0x12345678 -> inst_data_ok=data_data_ok=0, both rdata=0, state stays IDLE.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response bundle: req + fields go out, addr_ok/data_ok/rdata
// come back. The arbiter is the slave of both pipeline ports and the master of
// the bus port.
interface sram_bus_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-to-one arbiter sharing a single SRAM-like bus port between the fetch
// (inst) and memory-stage (data) ports. One transaction may be outstanding at a
// time. Data has fixed priority, but after MAX_DATA_STREAK consecutive data
// grants taken while a fetch was waiting, the fetch is granted next.
// Requests reach the bus combinationally (zero-cycle request latency).
module sram_bus_arbiter #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   sram_bus_arbiter_if.slave         inst,
   sram_bus_arbiter_if.slave         data,
   sram_bus_arbiter_if.master        bus,
   output logic                      busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_DATA_STREAK);

   state_t      r_state;
   logic        r_owner;      // 0 = inst, 1 = data
   logic [3:0]  r_streak;     // data grants in a row while inst was waiting
   logic        r_out_en;     // low during reset and the first cycle after it

   logic        w_idle;
   logic        w_wait;
   logic        w_any_req;
   logic        w_sel_data;
   logic        w_bus_req;
   logic        w_accept;
   logic        w_resp;
   logic        w_wr;
   logic [1:0]  w_size;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;

   // Saturating 4-bit increment for the streak counter.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : (v + 4'd1);
   endfunction

   assign w_idle     = r_out_en && (r_state == S_IDLE);
   assign w_wait     = r_out_en && (r_state == S_WAIT);
   assign w_any_req  = inst.req | data.req;

   // Data wins unless inst is also waiting and the data streak is used up.
   assign w_sel_data = data.req && (!inst.req || (r_streak < LP_MAX_STREAK));

   assign w_bus_req  = w_idle & w_any_req;
   assign w_accept   = w_bus_req & bus.addr_ok;

   // A response only means something while a transaction is outstanding;
   // a stray bus_data_ok in IDLE is dropped.
   assign w_resp     = w_wait & bus.data_ok;

   // Steer the winner's request fields onto the bus; all zero when idle or empty.
   always_comb begin
      w_wr    = 1'b0;
      w_size  = 2'd0;
      w_addr  = 32'd0;
      w_wdata = 32'd0;
      if (w_bus_req) begin
         if (w_sel_data) begin
            w_wr    = data.wr;
            w_size  = data.size;
            w_addr  = data.addr;
            w_wdata = data.wdata;
         end else begin
            w_wr    = inst.wr;
            w_size  = inst.size;
            w_addr  = inst.addr;
            w_wdata = inst.wdata;
         end
      end
   end

   assign bus.req       = w_bus_req;
   assign bus.wr        = w_wr;
   assign bus.size      = w_size;
   assign bus.addr      = w_addr;
   assign bus.wdata     = w_wdata;

   assign inst.addr_ok  = w_accept & ~w_sel_data;
   assign data.addr_ok  = w_accept &  w_sel_data;

   assign inst.data_ok  = w_resp & ~r_owner;
   assign data.data_ok  = w_resp &  r_owner;
   assign inst.rdata    = (w_resp & ~r_owner) ? bus.rdata : 32'd0;
   assign data.rdata    = (w_resp &  r_owner) ? bus.rdata : 32'd0;

   assign busy          = (r_state == S_WAIT);

   // Arbiter FSM: latch the owner on acceptance, track the data streak, and
   // return to IDLE on the owner's response. Reset abandons any transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_streak <= 4'd0;
         r_out_en <= 1'b0;
      end else begin
         r_out_en <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_WAIT;
                  r_owner <= w_sel_data;
                  if (w_sel_data && inst.req) begin
                     r_streak <= sat_inc4(r_streak);
                  end else begin
                     r_streak <= 4'd0;
                  end
               end
            end
            S_WAIT: begin
               if (w_resp) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed request sequences with a response
// scoreboard. Each accepted transfer pushes the expected owner and read data;
// the negedge monitor pops an entry whenever a *_data_ok appears.
module tb_sram_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   always #5 clk = ~clk;

   sram_bus_arbiter_if u_inst ();
   sram_bus_arbiter_if u_data ();
   sram_bus_arbiter_if u_bus  ();

   sram_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .inst (u_inst),
      .data (u_data),
      .bus  (u_bus),
      .busy (busy)
   );

   typedef struct packed {
      logic        is_data;
      logic [31:0] rdata;
   } sb_t;

   sb_t sb_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven from here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input logic req, input logic [31:0] addr);
      u_inst.req   = req;
      u_inst.wr    = 1'b0;
      u_inst.size  = 2'd2;
      u_inst.addr  = addr;
      u_inst.wdata = 32'h0;
   endtask

   task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
      u_data.req   = req;
      u_data.wr    = wr;
      u_data.size  = 2'd2;
      u_data.addr  = addr;
      u_data.wdata = wdata;
   endtask

   // Accept the current winner this cycle, then complete after wait_cyc cycles.
   // Requests stay as the caller left them (held through WAIT).
   task automatic txn(input string tag, input bit exp_data, input int wait_cyc,
                      input logic [31:0] rd);
      u_bus.addr_ok = 1'b1;
      #2;
      chk({tag, "_bus_req"},  u_bus.req, 1'b1);
      chk({tag, "_inst_aok"}, u_inst.addr_ok, !exp_data);
      chk({tag, "_data_aok"}, u_data.addr_ok, exp_data);
      chk({tag, "_bus_addr"}, u_bus.addr,  exp_data ? u_data.addr  : u_inst.addr);
      chk({tag, "_bus_wr"},   u_bus.wr,    exp_data ? u_data.wr    : u_inst.wr);
      chk({tag, "_bus_wdat"}, u_bus.wdata, exp_data ? u_data.wdata : u_inst.wdata);
      sb_q.push_back('{is_data: exp_data, rdata: rd});
      for (int i = 0; i < wait_cyc; i++) begin
         cyc();
         u_bus.addr_ok = 1'b1;   // slave ready, must be ignored in WAIT
         u_bus.data_ok = (i == wait_cyc - 1);
         u_bus.rdata   = (i == wait_cyc - 1) ? rd : 32'h0;
         #2;
         chk({tag, "_w_busy"},    busy, 1'b1);
         chk({tag, "_w_bus_req"}, u_bus.req, 1'b0);
         chk({tag, "_w_aok"},     {u_inst.addr_ok, u_data.addr_ok}, 2'b00);
      end
      cyc();
      u_bus.addr_ok = 1'b0;
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;
   endtask

   // Response monitor: every *_data_ok must match the oldest accepted transfer.
   always @(negedge clk) begin
      if (u_inst.data_ok || u_data.data_ok) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_dok", {u_inst.data_ok, u_data.data_ok}, 2'b00);
         end else begin
            automatic sb_t e = sb_q.pop_front();
            chk("sb_data_dok",  u_data.data_ok, e.is_data);
            chk("sb_inst_dok",  u_inst.data_ok, !e.is_data);
            chk("sb_rdata",     e.is_data ? u_data.rdata : u_inst.rdata, e.rdata);
            chk("sb_other_rd",  e.is_data ? u_inst.rdata : u_data.rdata, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t limit=%0d", $time, 200000);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with live-looking inputs: everything must stay quiet.
      rst = 1'b1;
      set_inst(1'b1, 32'hBFC0_0000);
      set_data(1'b0, 1'b0, 32'h0, 32'h0);
      u_bus.addr_ok = 1'b1;
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'h5555_AAAA;
      #3;
      chk("rst_bus_req",  u_bus.req, 1'b0);
      chk("rst_inst_aok", u_inst.addr_ok, 1'b0);
      chk("rst_inst_dok", u_inst.data_ok, 1'b0);
      chk("rst_busy",     busy, 1'b0);
      #5;
      rst = 1'b0;
      #1;
      chk("post_rst_bus_req",  u_bus.req, 1'b0);
      chk("post_rst_inst_aok", u_inst.addr_ok, 1'b0);
      chk("post_rst_bus_addr", u_bus.addr, 32'h0);
      set_inst(1'b0, 32'h0);
      u_bus.addr_ok = 1'b0;
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;
      cyc();
      cyc();

      // Inst only; also leaves the streak at 0.
      set_inst(1'b1, 32'hBFC0_0000);
      txn("inst_only", 1'b0, 2, 32'h3C08_0001);
      set_inst(1'b0, 32'h0);

      // Simultaneous requests: data wins twice (streak 0 -> 1 -> 2).
      set_inst(1'b1, 32'hBFC0_0004);
      set_data(1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF);
      txn("simul_1", 1'b1, 2, 32'h0000_0000);
      txn("simul_2", 1'b1, 2, 32'h0000_0000);
      // Data alone clears the streak.
      set_inst(1'b0, 32'h0);
      txn("data_alone", 1'b1, 2, 32'h0000_0000);

      // Starvation guard: four data grants, then inst, then data again.
      set_inst(1'b1, 32'hBFC0_0100);
      set_data(1'b1, 1'b0, 32'h8000_2000, 32'h0);
      for (int k = 0; k < 4; k++) begin
         txn("starve_d", 1'b1, 2, 32'hD000_0000 + 32'(k));
      end
      txn("starve_i", 1'b0, 2, 32'h1000_0001);
      txn("starve_d_after", 1'b1, 2, 32'hD000_0010);
      set_inst(1'b0, 32'h0);
      set_data(1'b0, 1'b0, 32'h0, 32'h0);

      // Back-to-back: new data_req in the data_ok cycle waits for IDLE.
      set_data(1'b1, 1'b0, 32'h8000_3000, 32'h0);
      u_bus.addr_ok = 1'b1;
      #2;
      chk("b2b_first_aok", u_data.addr_ok, 1'b1);
      sb_q.push_back('{is_data: 1'b1, rdata: 32'hA5A5_0001});
      cyc();
      set_data(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("b2b_wait_busy", busy, 1'b1);
      cyc();
      set_data(1'b1, 1'b0, 32'h8000_3004, 32'h0);
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'hA5A5_0001;
      #2;
      chk("b2b_dok_cycle_aok",    u_data.addr_ok, 1'b0);
      chk("b2b_dok_cycle_busreq", u_bus.req, 1'b0);
      cyc();
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;
      #2;
      chk("b2b_next_aok",    u_data.addr_ok, 1'b1);
      chk("b2b_next_busreq", u_bus.req, 1'b1);
      chk("b2b_next_addr",   u_bus.addr, 32'h8000_3004);
      sb_q.push_back('{is_data: 1'b1, rdata: 32'hA5A5_0002});
      cyc();
      set_data(1'b0, 1'b0, 32'h0, 32'h0);
      u_bus.addr_ok = 1'b0;
      cyc();
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'hA5A5_0002;
      cyc();
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;

      // addr_ok and data_ok together in IDLE: accept, no response.
      set_inst(1'b1, 32'hBFC0_0200);
      u_bus.addr_ok = 1'b1;
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'hFFFF_0000;
      #2;
      chk("both_ok_inst_aok", u_inst.addr_ok, 1'b1);
      chk("both_ok_inst_dok", u_inst.data_ok, 1'b0);
      sb_q.push_back('{is_data: 1'b0, rdata: 32'h1111_2222});
      cyc();
      set_inst(1'b0, 32'h0);
      u_bus.addr_ok = 1'b0;
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;
      #2;
      chk("both_ok_busy", busy, 1'b1);
      cyc();
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'h1111_2222;
      cyc();
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;

      // Grant is not sticky: winner re-evaluated each IDLE cycle.
      set_data(1'b1, 1'b0, 32'h8000_4000, 32'h0);
      #2;
      chk("ns_data_busreq", u_bus.req, 1'b1);
      chk("ns_data_aok",    u_data.addr_ok, 1'b0);
      cyc();
      set_data(1'b0, 1'b0, 32'h0, 32'h0);
      set_inst(1'b1, 32'hBFC0_0300);
      #2;
      chk("ns_inst_addr", u_bus.addr, 32'hBFC0_0300);
      cyc();
      set_inst(1'b0, 32'h0);
      #2;
      chk("ns_none_busreq", u_bus.req, 1'b0);
      chk("ns_none_addr",   u_bus.addr, 32'h0);
      cyc();
      u_bus.addr_ok = 1'b1;
      #2;
      chk("ns_noreq_aok", {u_inst.addr_ok, u_data.addr_ok}, 2'b00);
      cyc();
      u_bus.addr_ok = 1'b0;
      #2;
      chk("ns_noreq_busy", busy, 1'b0);

      // Reset asserted mid-WAIT, no clock edge.
      cyc();
      set_data(1'b1, 1'b1, 32'h8000_5000, 32'h0BAD_F00D);
      u_bus.addr_ok = 1'b1;
      #2;
      chk("rw_aok", u_data.addr_ok, 1'b1);
      sb_q.push_back('{is_data: 1'b1, rdata: 32'hCAFE_0000});
      cyc();
      set_data(1'b0, 1'b0, 32'h0, 32'h0);
      u_bus.addr_ok = 1'b0;
      #2;
      chk("rw_busy_before", busy, 1'b1);
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'hCAFE_0000;
      rst = 1'b1;
      #1;
      chk("rw_busy",    busy, 1'b0);
      chk("rw_dok",     {u_inst.data_ok, u_data.data_ok}, 2'b00);
      chk("rw_aok_rst", {u_inst.addr_ok, u_data.addr_ok}, 2'b00);
      sb_q.delete();
      rst = 1'b0;
      #1;
      chk("rw_post_dok", {u_inst.data_ok, u_data.data_ok}, 2'b00);
      cyc();
      #2;
      chk("rw_stray_dok",   {u_inst.data_ok, u_data.data_ok}, 2'b00);
      chk("rw_stray_drd",   u_data.rdata, 32'h0);
      chk("rw_stray_busy",  busy, 1'b0);
      cyc();
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;

      // Stray data_ok in IDLE with no request.
      cyc();
      u_bus.data_ok = 1'b1;
      u_bus.rdata   = 32'h1234_5678;
      #2;
      chk("stray_dok",  {u_inst.data_ok, u_data.data_ok}, 2'b00);
      chk("stray_ird",  u_inst.rdata, 32'h0);
      chk("stray_drd",  u_data.rdata, 32'h0);
      chk("stray_busy", busy, 1'b0);
      cyc();
      u_bus.data_ok = 1'b0;
      u_bus.rdata   = 32'h0;
      #2;
      chk("stray_busy_next", busy, 1'b0);

      cyc();
      chk("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
